// File: rtl/bombe_search_controller_if.sv
// ---------------------------------------------------------------------------
// bombe_search_controller_if
//   Bundles the character-input handshake, the datapath request/response
//   signals and the status outputs of the Bombe search controller.
//
//   master : environment side (top-level input logic + Enigma datapath);
//            drives char_in/char_valid and dp_ack/dp_cipher.
//   slave  : controller side; drives char_ready, dp_load/dp_pos_*,
//            dp_req/dp_plain and the busy/done/found/error/set_* status.
// ---------------------------------------------------------------------------
interface bombe_search_controller_if #(
  parameter int POS_W = 5
);
  logic [7:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic             dp_load;
  logic [POS_W-1:0] dp_pos_l;
  logic [POS_W-1:0] dp_pos_m;
  logic [POS_W-1:0] dp_pos_r;
  logic             dp_req;
  logic [7:0]       dp_plain;
  logic             dp_ack;
  logic [7:0]       dp_cipher;
  logic             busy;
  logic             done;
  logic             found;
  logic             error;
  logic [POS_W-1:0] set_l;
  logic [POS_W-1:0] set_m;
  logic [POS_W-1:0] set_r;

  modport master (
    output char_in, char_valid, dp_ack, dp_cipher,
    input  char_ready, dp_load, dp_pos_l, dp_pos_m, dp_pos_r, dp_req,
           dp_plain, busy, done, found, error, set_l, set_m, set_r
  );

  modport slave (
    input  char_in, char_valid, dp_ack, dp_cipher,
    output char_ready, dp_load, dp_pos_l, dp_pos_m, dp_pos_r, dp_req,
           dp_plain, busy, done, found, error, set_l, set_m, set_r
  );
endinterface

// File: rtl/bombe_search_controller.sv
// ---------------------------------------------------------------------------
// bombe_search_controller
//   Collects three ASCII flag characters S0..S2, then walks every rotor
//   setting (L,M,R) in odometer order. For each setting the datapath is
//   loaded and asked to encrypt 'A','B','C' in turn; each ciphertext is
//   compared against the matching flag with early-out on mismatch. Stops on
//   the first full match (FOUND), after the last setting (FAIL), or on a bad
//   character / datapath ack timeout (ERROR).
//
//   Ports:
//     clock   : system clock, rising edge
//     resetn  : asynchronous active-low reset
//     bus     : bombe_search_controller_if.slave (char handshake, datapath
//               load/req/ack, status and matching setting)
// ---------------------------------------------------------------------------
module bombe_search_controller #(
  parameter int N_POS       = 26,
  parameter int POS_W       = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                        clock,
  input  logic                        resetn,
  bombe_search_controller_if.slave    bus
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_GET1  = 4'd1;
  localparam logic [3:0] S_GET2  = 4'd2;
  localparam logic [3:0] S_LOAD  = 4'd3;
  localparam logic [3:0] S_REQ   = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_CHECK = 4'd6;
  localparam logic [3:0] S_INC   = 4'd7;
  localparam logic [3:0] S_FOUND = 4'd8;
  localparam logic [3:0] S_FAIL  = 4'd9;
  localparam logic [3:0] S_ERROR = 4'd10;

  localparam int               CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_POS - 1);

  logic [3:0]       state_q, state_d;
  logic [7:0]       flag0_q, flag0_d;
  logic [7:0]       flag1_q, flag1_d;
  logic [7:0]       flag2_q, flag2_d;
  logic [POS_W-1:0] pos_l_q, pos_l_d;
  logic [POS_W-1:0] pos_m_q, pos_m_d;
  logic [POS_W-1:0] pos_r_q, pos_r_d;
  logic [1:0]       k_q, k_d;
  logic [7:0]       plain_q, plain_d;
  logic [7:0]       cipher_q, cipher_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic       char_ready;
  logic       char_fire;
  logic       char_ok;
  logic [7:0] flag_sel;
  logic       last_cand;

  // Terminal states double as "ready for a new S0".
  assign char_ready = (state_q == S_IDLE)  || (state_q == S_GET1) ||
                      (state_q == S_GET2)  || (state_q == S_FOUND) ||
                      (state_q == S_FAIL)  || (state_q == S_ERROR);
  assign char_fire  = bus.char_valid && char_ready;
  assign char_ok    = (bus.char_in >= 8'h41) && (bus.char_in <= 8'h5A);
  assign last_cand  = (pos_l_q == POS_MAX) && (pos_m_q == POS_MAX) &&
                      (pos_r_q == POS_MAX);

  always_comb begin
    flag_sel = flag0_q;
    case (k_q)
      2'd1:    flag_sel = flag1_q;
      2'd2:    flag_sel = flag2_q;
      default: flag_sel = flag0_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    flag0_d  = flag0_q;
    flag1_d  = flag1_q;
    flag2_d  = flag2_q;
    pos_l_d  = pos_l_q;
    pos_m_d  = pos_m_q;
    pos_r_d  = pos_r_q;
    k_d      = k_q;
    plain_d  = plain_q;
    cipher_d = cipher_q;
    wait_d   = wait_q;

    case (state_q)
      S_IDLE, S_FOUND, S_FAIL, S_ERROR: begin
        if (char_fire) begin
          if (char_ok) begin
            flag0_d = bus.char_in;
            state_d = S_GET1;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_GET1: begin
        if (char_fire) begin
          if (char_ok) begin
            flag1_d = bus.char_in;
            state_d = S_GET2;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_GET2: begin
        if (char_fire) begin
          if (char_ok) begin
            flag2_d = bus.char_in;
            pos_l_d = '0;
            pos_m_d = '0;
            pos_r_d = '0;
            k_d     = 2'd0;
            state_d = S_LOAD;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_LOAD: begin
        k_d     = 2'd0;
        plain_d = 8'h41;
        state_d = S_REQ;
      end
      S_REQ: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (bus.dp_ack) begin
          cipher_d = bus.dp_cipher;
          state_d  = S_CHECK;
        end else if (wait_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (cipher_q != flag_sel) begin
          state_d = S_INC;
        end else if (k_q == 2'd2) begin
          state_d = S_FOUND;
        end else begin
          k_d     = k_q + 2'd1;
          plain_d = 8'h42 + {6'd0, k_q};
          state_d = S_REQ;
        end
      end
      S_INC: begin
        // The final candidate is left in place so it can be inspected.
        if (last_cand) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_LOAD;
          if (pos_r_q == POS_MAX) begin
            pos_r_d = '0;
            if (pos_m_q == POS_MAX) begin
              pos_m_d = '0;
              pos_l_d = pos_l_q + 1'b1;
            end else begin
              pos_m_d = pos_m_q + 1'b1;
            end
          end else begin
            pos_r_d = pos_r_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      flag0_q  <= '0;
      flag1_q  <= '0;
      flag2_q  <= '0;
      pos_l_q  <= '0;
      pos_m_q  <= '0;
      pos_r_q  <= '0;
      k_q      <= '0;
      plain_q  <= '0;
      cipher_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      flag0_q  <= flag0_d;
      flag1_q  <= flag1_d;
      flag2_q  <= flag2_d;
      pos_l_q  <= pos_l_d;
      pos_m_q  <= pos_m_d;
      pos_r_q  <= pos_r_d;
      k_q      <= k_d;
      plain_q  <= plain_d;
      cipher_q <= cipher_d;
      wait_q   <= wait_d;
    end
  end

  assign bus.char_ready = char_ready;
  assign bus.dp_load    = (state_q == S_LOAD);
  assign bus.dp_req     = (state_q == S_REQ);
  assign bus.dp_pos_l   = pos_l_q;
  assign bus.dp_pos_m   = pos_m_q;
  assign bus.dp_pos_r   = pos_r_q;
  assign bus.dp_plain   = plain_q;
  assign bus.busy       = (state_q >= S_GET1) && (state_q <= S_INC);
  assign bus.done       = (state_q == S_FOUND) || (state_q == S_FAIL) ||
                          (state_q == S_ERROR);
  assign bus.found      = (state_q == S_FOUND);
  assign bus.error      = (state_q == S_ERROR);
  // The candidate is frozen in FOUND, so it is the matching setting.
  assign bus.set_l      = (state_q == S_FOUND) ? pos_l_q : '0;
  assign bus.set_m      = (state_q == S_FOUND) ? pos_m_q : '0;
  assign bus.set_r      = (state_q == S_FOUND) ? pos_r_q : '0;

endmodule

// File: tb/tb_bombe_search_controller.sv
// ---------------------------------------------------------------------------
// tb_bombe_search_controller
//   Directed bench for bombe_search_controller. A behavioural datapath
//   responds to dp_req one cycle later with
//     cipher = 'A' + ((plain-'A') + L + M + R + k) mod 26
//   or, depending on model_mode, always 'A', never acks, or matches only at
//   setting (1,0,0).
// ---------------------------------------------------------------------------
module tb_bombe_search_controller;
  localparam int N_POS       = 26;
  localparam int POS_W       = 5;
  localparam int ACK_TIMEOUT = 255;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  bombe_search_controller_if #(.POS_W(POS_W)) bus ();

  bombe_search_controller #(
    .N_POS      (N_POS),
    .POS_W      (POS_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // 0: formula, 1: always 'A', 2: never ack, 3: match only at (1,0,0)
  int         model_mode   = 0;
  logic       model_ack    = 1'b0;
  logic [7:0] model_cipher = 8'h00;
  logic       tb_ack       = 1'b0;
  logic [7:0] tb_cipher    = 8'h00;

  assign bus.dp_ack    = model_ack | tb_ack;
  assign bus.dp_cipher = tb_ack ? tb_cipher : model_cipher;

  int         load_cnt  = 0;
  int         req_cnt   = 0;
  logic [4:0] ml        = 5'd0;
  logic [4:0] mm        = 5'd0;
  logic [4:0] mr        = 5'd0;
  logic       saw_carry = 1'b0;

  function automatic logic [7:0] model_fn(input int md, input logic [4:0] l,
                                          input logic [4:0] m, input logic [4:0] r,
                                          input logic [7:0] plain);
    int k;
    int v;
    k = int'(plain) - 65;
    if (md == 1) return 8'h41;
    if (md == 3) return (l == 5'd1 && m == 5'd0 && r == 5'd0) ? plain : 8'h5A;
    v = 65 + ((k + int'(l) + int'(m) + int'(r) + k) % 26);
    return v[7:0];
  endfunction

  always @(posedge clock) begin
    if (bus.dp_load) begin
      load_cnt <= load_cnt + 1;
      ml <= bus.dp_pos_l;
      mm <= bus.dp_pos_m;
      mr <= bus.dp_pos_r;
      if (ml == 5'd0 && mm == 5'd25 && mr == 5'd25 &&
          bus.dp_pos_l == 5'd1 && bus.dp_pos_m == 5'd0 && bus.dp_pos_r == 5'd0)
        saw_carry <= 1'b1;
    end
    if (bus.dp_req) req_cnt <= req_cnt + 1;
    if (bus.dp_req && model_mode != 2) begin
      model_ack    <= 1'b1;
      model_cipher <= model_fn(model_mode, ml, mm, mr, bus.dp_plain);
    end else begin
      model_ack <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clock);
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.char_valid = 1'b0;
    $display("char 0x%02h presented, busy=%0b done=%0b err=%0b", c, bus.busy, bus.done, bus.error);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    tick(2);
    @(negedge clock);
    resetn = 1'b1;
    tick(1);
  endtask

  task automatic wait_req(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!bus.dp_req && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(tag, 32'(bus.dp_req), 32'd1);
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!bus.done && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(tag, 32'(bus.done), 32'd1);
  endtask

  int snap_req;
  int snap_load;
  int n_to;

  initial begin
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;

    // Reset state
    tick(3);
    check("rst_char_ready", 32'(bus.char_ready), 32'd1);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_found",      32'(bus.found),      32'd0);
    check("rst_error",      32'(bus.error),      32'd0);
    check("rst_dp_load",    32'(bus.dp_load),    32'd0);
    check("rst_dp_req",     32'(bus.dp_req),     32'd0);
    check("rst_dp_plain",   32'(bus.dp_plain),   32'd0);
    check("rst_set_r",      32'(bus.set_r),      32'd0);
    @(negedge clock);
    resetn = 1'b1;
    tick(1);
    $display("reset released");

    // Reset while waiting for an ack
    model_mode = 2;
    send_char(8'h44);
    send_char(8'h46);
    send_char(8'h48);
    wait_req(10, "midwait_req_seen");
    tick(3);
    check("midwait_busy", 32'(bus.busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("midwait_rst_busy",  32'(bus.busy),       32'd0);
    check("midwait_rst_ready", 32'(bus.char_ready), 32'd1);
    snap_req   = req_cnt;
    snap_load  = load_cnt;
    model_mode = 0;
    tick(2);
    @(negedge clock);
    resetn = 1'b1;
    tick(20);
    check("midwait_no_req",  32'(req_cnt),  32'(snap_req));
    check("midwait_no_load", 32'(load_cnt), 32'(snap_load));
    check("midwait_ready",   32'(bus.char_ready), 32'd1);
    check("midwait_done",    32'(bus.done),  32'd0);
    check("midwait_found",   32'(bus.found), 32'd0);
    $display("mid-WAIT reset step complete");

    // "DFH" -> found at (0,0,3)
    snap_req  = req_cnt;
    snap_load = load_cnt;
    send_char(8'h44);
    send_char(8'h46);
    send_char(8'h48);
    wait_done(200, "dfh_done");
    check("dfh_found", 32'(bus.found), 32'd1);
    check("dfh_error", 32'(bus.error), 32'd0);
    check("dfh_busy",  32'(bus.busy),  32'd0);
    check("dfh_set_l", 32'(bus.set_l), 32'd0);
    check("dfh_set_m", 32'(bus.set_m), 32'd0);
    check("dfh_set_r", 32'(bus.set_r), 32'd3);
    check("dfh_loads", 32'(load_cnt - snap_load), 32'd4);
    check("dfh_reqs",  32'(req_cnt - snap_req),   32'd6);
    $display("DFH search step complete");

    // Lower-case second character -> ERROR, then restart
    send_char(8'h41);
    check("bad_get1_busy", 32'(bus.busy),  32'd1);
    check("bad_get1_done", 32'(bus.done),  32'd0);
    check("bad_get1_set",  32'(bus.set_r), 32'd0);
    send_char(8'h61);
    check("bad_error", 32'(bus.error), 32'd1);
    check("bad_done",  32'(bus.done),  32'd1);
    check("bad_busy",  32'(bus.busy),  32'd0);
    check("bad_found", 32'(bus.found), 32'd0);
    send_char(8'h42);
    check("restart_busy",  32'(bus.busy),  32'd1);
    check("restart_error", 32'(bus.error), 32'd0);
    check("restart_done",  32'(bus.done),  32'd0);
    do_reset();

    // Ack timeout
    model_mode = 2;
    send_char(8'h41);
    send_char(8'h42);
    send_char(8'h43);
    wait_req(10, "to_req_seen");
    n_to = 0;
    while (!bus.error && n_to < 1000) begin
      tick(1);
      n_to++;
    end
    check("to_cycles", 32'(n_to), 32'(ACK_TIMEOUT + 1));
    check("to_done",   32'(bus.done), 32'd1);
    check("to_busy",   32'(bus.busy), 32'd0);
    do_reset();
    model_mode = 0;

    // Ack while idle is ignored
    snap_load = load_cnt;
    @(negedge clock);
    tb_ack    = 1'b1;
    tb_cipher = 8'h41;
    @(negedge clock);
    tb_ack    = 1'b0;
    tick(3);
    check("idle_ack_busy",  32'(bus.busy),       32'd0);
    check("idle_ack_done",  32'(bus.done),       32'd0);
    check("idle_ack_error", 32'(bus.error),      32'd0);
    check("idle_ack_ready", 32'(bus.char_ready), 32'd1);
    check("idle_ack_load",  32'(load_cnt),       32'(snap_load));
    $display("timeout and idle-ack steps complete");

    // Carry from (0,25,25) to (1,0,0)
    model_mode = 3;
    snap_load  = load_cnt;
    send_char(8'h41);
    send_char(8'h42);
    send_char(8'h43);
    wait_done(5000, "carry_done");
    check("carry_found", 32'(bus.found), 32'd1);
    check("carry_set_l", 32'(bus.set_l), 32'd1);
    check("carry_set_m", 32'(bus.set_m), 32'd0);
    check("carry_set_r", 32'(bus.set_r), 32'd0);
    check("carry_seen",  32'(saw_carry), 32'd1);
    check("carry_loads", 32'(load_cnt - snap_load), 32'd677);
    $display("carry search step complete");

    // Exhaustive search with no match
    do_reset();
    model_mode = 1;
    snap_load  = load_cnt;
    send_char(8'h5A);
    send_char(8'h5A);
    send_char(8'h5A);
    wait_done(90000, "zzz_done");
    check("zzz_found", 32'(bus.found), 32'd0);
    check("zzz_error", 32'(bus.error), 32'd0);
    check("zzz_busy",  32'(bus.busy),  32'd0);
    check("zzz_set_l", 32'(bus.set_l), 32'd0);
    check("zzz_loads", 32'(load_cnt - snap_load), 32'd17576);
    check("zzz_last_l", 32'(ml), 32'd25);
    check("zzz_last_m", 32'(mm), 32'd25);
    check("zzz_last_r", 32'(mr), 32'd25);
    $display("exhaustive search step complete");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
